noc_eject_port: RTL and testbench

NOC_EJECT_PORT -- requirements
Module: noc_eject_port

---
 rtl/noc_eject_port_pkg.sv | 20 ++
 rtl/spike_fifo.sv | 69 ++++++
 rtl/noc_eject_port.sv | 136 +++++++++++++
 tb/tb_noc_eject_port.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/noc_eject_port_pkg.sv
// rtl/noc_eject_port_pkg.sv - shared NoC eject-port register map, STATUS layout and FSM encodings
package noc_eject_port_pkg;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_DATA   = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;

    localparam int STAT_EMPTY_BIT     = 0;
    localparam int STAT_FULL_BIT      = 1;
    localparam int STAT_UNDERFLOW_BIT = 2;
    localparam int STAT_COUNT_LSB     = 8;
    localparam int STAT_COUNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } acc_state_e;

endpackage

// File: rtl/spike_fifo.sv
// rtl/spike_fifo.sv - synchronous flit FIFO with occupancy count; storage is not reset
module spike_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wptr_q, wptr_d;
    logic [AW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    // A push while full is refused even if a pop lands on the same edge.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop_ok) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/noc_eject_port.sv
// rtl/noc_eject_port.sv - NoC eject port: buffers router flits and exposes them through a CPU register window
module noc_eject_port
    import noc_eject_port_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            mem_address,
    input  logic [DATA_WIDTH-1:0] mem_writedata,
    output logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  mem_busywait,
    output logic                  irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                  fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;

    acc_state_e            state_q, state_d;
    logic                  op_read_q, op_write_q, ctrl_clr_q;
    logic [3:0]            addr_q;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
    logic [DATA_WIDTH-1:0] status_w, rd_mux;
    logic                  busy_c, do_access, data_rd;
    logic                  unused_wdata;

    assign unused_wdata = ^mem_writedata[DATA_WIDTH-1:1];

    spike_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .data_i  (in_flit),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Handshake outputs are forced low for the whole time reset is held.
    assign in_ready     = !fifo_full && !rst;
    assign mem_busywait = busy_c && !rst;
    assign irq          = !fifo_empty;
    assign mem_readdata = readdata_q;

    always_comb begin
        status_w                                   = '0;
        status_w[STAT_EMPTY_BIT]                   = fifo_empty;
        status_w[STAT_FULL_BIT]                    = fifo_full;
        status_w[STAT_UNDERFLOW_BIT]               = underflow_q;
        status_w[STAT_COUNT_LSB +: STAT_COUNT_W]   = STAT_COUNT_W'(fifo_count);
    end

    always_comb begin
        rd_mux = '0;
        case (addr_q)
            REG_STATUS: rd_mux = status_w;
            REG_DATA:   rd_mux = fifo_empty ? '0 : fifo_head;
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        busy_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_c = mem_read || mem_write;
                if (mem_read || mem_write) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                busy_c  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The register side effect happens on the edge that leaves ACCESS.
    assign do_access = (state_q == ST_ACCESS);
    assign data_rd   = do_access && op_read_q && (addr_q == REG_DATA);
    assign fifo_pop  = data_rd && !fifo_empty;

    always_comb begin
        underflow_d = underflow_q;
        readdata_d  = readdata_q;
        if (data_rd && fifo_empty) begin
            underflow_d = 1'b1;
        end else if (do_access && op_write_q && (addr_q == REG_CTRL) && ctrl_clr_q) begin
            underflow_d = 1'b0;
        end
        if (do_access && op_read_q) begin
            readdata_d = rd_mux;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_read_q   <= 1'b0;
            op_write_q  <= 1'b0;
            ctrl_clr_q  <= 1'b0;
            addr_q      <= '0;
            underflow_q <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            underflow_q <= underflow_d;
            readdata_q  <= readdata_d;
            if (state_q == ST_IDLE && (mem_read || mem_write)) begin
                op_read_q  <= mem_read;
                op_write_q <= mem_write && !mem_read;
                addr_q     <= mem_address;
                ctrl_clr_q <= mem_writedata[0];
            end
        end
    end

endmodule

// File: tb/tb_noc_eject_port.sv
// tb/tb_noc_eject_port.sv - directed and table-driven bench for noc_eject_port
module tb_noc_eject_port;

    logic        clk;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    noc_eject_port #(.DATA_WIDTH(32), .FIFO_DEPTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_flit       (in_flit),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait),
        .irq           (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t        vt [16];
    logic [31:0] sb [$];
    logic [31:0] rdata;
    int          busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cpu_access(input logic rd, input logic wr, input logic [3:0] addr,
                              input logic [31:0] wd, output logic [31:0] rdat, output int nbusy);
        logic done;
        done  = 1'b0;
        nbusy = 0;
        rdat  = '0;
        @(negedge clk);
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = wd;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!mem_busywait) begin
                rdat = mem_readdata;
                done = 1'b1;
                break;
            end
            nbusy++;
            @(negedge clk);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check("cpu_handshake_done", {31'd0, done}, 32'd1);
    endtask

    task automatic push_flit(input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        in_flit  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("push_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic read_expect(input string name, input logic [3:0] addr, input logic [31:0] exp);
        cpu_access(1'b1, 1'b0, addr, 32'd0, rdata, busy);
        check(name, rdata, exp);
        check({name, "_busy"}, busy, 2);
    endtask

    initial begin
        rst = 1'b1; in_flit = '0; in_valid = 1'b0;
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 4'h4; mem_writedata = '0;

        // Reset values, with a read request pending to prove busywait is gated
        @(negedge clk); #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_busywait", {31'd0, mem_busywait}, 32'd0);
        check("rst_readdata", mem_readdata, 32'd0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Table-driven register traffic on top of three buffered flits
        vt[0]  = '{1'b1, 1'b0, 4'h4, 32'h0,    1'b1, 32'h000000A1, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000200, 1'b1};
        vt[2]  = '{1'b1, 1'b0, 4'h4, 32'h0,    1'b1, 32'h000000A2, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 4'h4, 32'h0,    1'b1, 32'h000000A3, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000001, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 4'h4, 32'h0,    1'b1, 32'h00000000, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000005, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 4'h0, 32'hFFFF, 1'b0, 32'h0,        1'b0};
        vt[8]  = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000005, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 4'h8, 32'h0,    1'b0, 32'h0,        1'b0};
        vt[10] = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000005, 1'b0};
        vt[11] = '{1'b1, 1'b1, 4'h8, 32'h1,    1'b0, 32'h0,        1'b0};
        vt[12] = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000005, 1'b0};
        vt[13] = '{1'b0, 1'b1, 4'h8, 32'h1,    1'b0, 32'h0,        1'b0};
        vt[14] = '{1'b1, 1'b0, 4'h0, 32'h0,    1'b1, 32'h00000001, 1'b0};
        vt[15] = '{1'b1, 1'b0, 4'hC, 32'h0,    1'b1, 32'h00000000, 1'b0};

        push_flit(32'hA1);
        push_flit(32'hA2);
        push_flit(32'hA3);
        for (int i = 0; i < 16; i++) begin
            cpu_access(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, rdata, busy);
            check($sformatf("vec%0d_busy", i), busy, 2);
            check($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
            if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp_rd);
        end

        // Fill to full with in_valid held; the ninth flit waits for a pop
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            in_flit  = k;
            in_valid = 1'b1;
            #1;
            check($sformatf("fill%0d_ready", k), {31'd0, in_ready}, 32'd1);
        end
        @(negedge clk);
        in_flit = 32'd9;
        #1;
        check("full_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk); #1;
        check("full_ready_held", {31'd0, in_ready}, 32'd0);
        read_expect("full_status", 4'h0, 32'h00000802);
        read_expect("full_pop1", 4'h4, 32'd1);
        check("ready_after_pop", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        read_expect("refill_status", 4'h0, 32'h00000802);
        for (int k = 2; k <= 9; k++) read_expect($sformatf("drain%0d", k), 4'h4, k);
        read_expect("drained_status", 4'h0, 32'h00000001);

        // Pop and push on the same edge at count 3
        push_flit(32'hB1);
        push_flit(32'hB2);
        push_flit(32'hB3);
        @(negedge clk);
        mem_read = 1'b1; mem_address = 4'h4;
        @(negedge clk);
        in_flit = 32'hB4; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pp_busy_low", {31'd0, mem_busywait}, 32'd0);
        check("pp_rdata", mem_readdata, 32'hB1);
        mem_read = 1'b0;
        read_expect("pp_status", 4'h0, 32'h00000300);
        read_expect("pp_b2", 4'h4, 32'hB2);
        read_expect("pp_b3", 4'h4, 32'hB3);
        read_expect("pp_b4", 4'h4, 32'hB4);

        // Reset during ACCESS of a DATA read
        push_flit(32'hC1);
        push_flit(32'hC2);
        @(negedge clk);
        mem_read = 1'b1; mem_address = 4'h4;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, mem_busywait}, 32'd0);
        check("midrst_rdata", mem_readdata, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        mem_read = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_rdata_after", mem_readdata, 32'd0);
        read_expect("midrst_status", 4'h0, 32'h00000001);

        // 20 flits interleaved with reads, checked against a scoreboard
        for (int i = 0; i < 20; i++) begin
            push_flit(32'h100 + i);
            sb.push_back(32'h100 + i);
            if (i % 4 != 3) read_expect($sformatf("wrap_rd%0d", i), 4'h4, sb.pop_front());
        end
        read_expect("wrap_status", 4'h0, 32'h00000500);
        while (sb.size() > 0) read_expect("wrap_drain", 4'h4, sb.pop_front());
        read_expect("wrap_end_status", 4'h0, 32'h00000001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
